avmm_noc_responder: RTL
=======================

# avmm_noc_responder

Avalon-MM responder (slave) terminating the 20-bit/32-bit AVMM master port that each PR user-logic region drives into the test NoC. Services single-beat reads and writes against a small register bank plus an on-chip scratch memory, with fixed-latency pipelined read returns. A programmable waitrequest stall injector lets the responder exercise master backpressure handling. One instance per PR sector endpoint.

## Interface
- ADDR_W, 20, byte address width
- DATA_W, 32, data width (fixed 32; byteenable is DATA_W/8)
- MEM_WORDS, 256, scratch memory depth in words (power of 2, ≤1024)
- READ_LATENCY, 2, cycles from read accept to readdatavalid (≥1)
- ID_VALUE, 32'h5EC7_0007, value of ID register

- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- avmm_slave_address  in  ADDR_W  byte address; bits [1:0] ignored
- avmm_slave_read  in  1  read request
- avmm_slave_write  in  1  write request
- avmm_slave_writedata  in  32  write data
- avmm_slave_byteenable  in  4  byte lanes; applied to memory writes only, registers take full word
- avmm_slave_waitrequest  out  1  command not accepted this cycle
- avmm_slave_readdata  out  32  read return data
- avmm_slave_readdatavalid  out  1  readdata valid

## Operation
- Accept: command accepted in a cycle where (read|write) && !waitrequest. No bursts (burstcount absent, always 1).
- Address map (byte offsets):
  - 0x00000 ID, RO, ID_VALUE
  - 0x00004 WR_COUNT, RO, accepted writes, wraps mod 2^32
  - 0x00008 RD_COUNT, RO, accepted reads, wraps mod 2^32
  - 0x0000C STATUS, bit0 sticky decode error, write-1-to-clear; other bits read 0
  - 0x00010 STALL_CFG, RW, bits[3:0] = N; other bits read 0
  - 0x01000 + 4*i, memory word i, i < MEM_WORDS
- Unmapped read: returns 32'hDEAD_BEEF, sets error. Unmapped write or write to RO register: dropped, sets error. Counters still increment.
- read && write together: illegal; no state change except error set; counters unchanged; one readdatavalid returns 32'hDEAD_BEEF.
- Read data sampled in accept cycle: a read of WR_COUNT/RD_COUNT excludes its own command; a later write never alters an already-accepted read.
- Stall injector: counts accepted commands; when count reaches N (N≠0), waitrequest forced high for exactly one cycle, count cleared. N=0 disables. New N applies from the command after the STALL_CFG write.

## Timing
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, counters=0, STALL_CFG=0, error=0. Memory contents not reset.
- waitrequest drops in the first cycle after rst deasserts; otherwise depends only on stall state (registered, independent of read/write).
- Read accepted in cycle c → readdatavalid=1 with data in cycle c+READ_LATENCY exactly; no return backpressure. Back-to-back reads → back-to-back readdatavalid, in order.
- Write accepted in cycle c is visible to a read accepted in cycle c+1.
- STATUS write-1 and a new error in the same cycle: error stays set.
- rst mid-operation: all in-flight reads discarded, readdatavalid=0 from the cycle after rst is sampled high.
- readdata holds last returned value when readdatavalid=0.

## Structure
- Package avmm_noc_pkg: register offsets, MEM_BASE, ERR_DATA (32'hDEAD_BEEF), STALL field width.
- Sub-module avmm_rd_delay_pipe: READ_LATENCY-deep valid+data shift register with synchronous clear; top level holds decode, registers, memory, stall counter.

## Test plan
- Reset release, read 0x00000 → waitrequest low 1 cycle after rst falls; readdatavalid with 32'h5EC7_0007 exactly 2 cycles after accept.
- Write 0x01004=0xA5A5_5A5A, byteenable=4'b0011 over prior 0xFFFF_FFFF, read next cycle → 0xFFFF_5A5A; WR_COUNT read → 1.
- 8 back-to-back reads of memory words 0..7 → 8 consecutive readdatavalid pulses in order; RD_COUNT then returns 8.
- Read 0x20000 → 32'hDEAD_BEEF, STATUS=1; write STATUS=1 → STATUS reads 0; read+write asserted together → one 0xDEAD_BEEF return, counters unchanged.
- STALL_CFG=3, issue 9 writes continuously → waitrequest high one cycle after 3rd, 6th, 9th accept; all 9 land.
- Assert rst 1 cycle after accepting 2 reads → no readdatavalid afterwards; WR_COUNT/RD_COUNT read 0.

Source files
------------

// File: rtl/avmm_noc_pkg.sv
// Shared constants for the AVMM NoC responder: register map, memory window,
// error return pattern and stall field width.
package avmm_noc_pkg;

  localparam logic [19:0] ID_OFF        = 20'h00000;
  localparam logic [19:0] WR_COUNT_OFF  = 20'h00004;
  localparam logic [19:0] RD_COUNT_OFF  = 20'h00008;
  localparam logic [19:0] STATUS_OFF    = 20'h0000C;
  localparam logic [19:0] STALL_CFG_OFF = 20'h00010;
  localparam logic [19:0] MEM_BASE      = 20'h01000;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int          STALL_W  = 4;

  // Decoded target of the current command.
  typedef enum logic [2:0] {
    SEL_ID,
    SEL_WR_CNT,
    SEL_RD_CNT,
    SEL_STATUS,
    SEL_STALL,
    SEL_MEM,
    SEL_NONE
  } sel_e;

endpackage

// File: rtl/avmm_rd_delay_pipe.sv
// Fixed-depth valid+data delay line for read returns. Data stages only load
// when the stage feeding them is valid, so the last stage keeps the most
// recently returned word while no return is in flight.
module avmm_rd_delay_pipe #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              dly_valid,
  output logic [DATA_W-1:0] dly_data
);

  logic [DEPTH-1:0]  valid_r;
  logic [DATA_W-1:0] data_r [DEPTH];

  // Shift valid/data one stage per cycle; clear drops everything in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= src_valid;
      if (src_valid) begin
        data_r[0] <= src_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign dly_valid = valid_r[DEPTH-1];
  assign dly_data  = data_r[DEPTH-1];

endmodule

// File: rtl/avmm_noc_responder.sv
// Avalon-MM responder for a PR sector endpoint: small register bank, scratch
// memory, fixed-latency pipelined read returns and a waitrequest stall injector.
module avmm_noc_responder
  import avmm_noc_pkg::*;
#(
  parameter int          ADDR_W       = 20,
  parameter int          DATA_W       = 32,
  parameter int          MEM_WORDS    = 256,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] ID_VALUE     = 32'h5EC7_0007
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   avmm_slave_address,
  input  logic                avmm_slave_read,
  input  logic                avmm_slave_write,
  input  logic [DATA_W-1:0]   avmm_slave_writedata,
  input  logic [DATA_W/8-1:0] avmm_slave_byteenable,
  output logic                avmm_slave_waitrequest,
  output logic [DATA_W-1:0]   avmm_slave_readdata,
  output logic                avmm_slave_readdatavalid
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int MEM_AW = $clog2(MEM_WORDS);

  localparam logic [WORD_W-1:0] W_ID     = WORD_W'(ID_OFF >> 2);
  localparam logic [WORD_W-1:0] W_WR_CNT = WORD_W'(WR_COUNT_OFF >> 2);
  localparam logic [WORD_W-1:0] W_RD_CNT = WORD_W'(RD_COUNT_OFF >> 2);
  localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(STATUS_OFF >> 2);
  localparam logic [WORD_W-1:0] W_STALL  = WORD_W'(STALL_CFG_OFF >> 2);
  localparam logic [WORD_W-1:0] MEM_LO   = WORD_W'(MEM_BASE >> 2);
  localparam logic [WORD_W-1:0] MEM_HI   = WORD_W'((MEM_BASE >> 2) + MEM_WORDS);

  logic                accept_s;
  logic                rd_push_s;
  logic                rd_acc_s;
  logic                wr_acc_s;
  logic                err_set_s;
  logic                err_clr_s;
  logic [WORD_W-1:0]   word_s;
  logic [MEM_AW-1:0]   mem_idx_s;
  sel_e                sel_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic [STALL_W:0]    stall_nxt_s;

  logic                waitrequest_r;
  logic [31:0]         wr_cnt_r;
  logic [31:0]         rd_cnt_r;
  logic                err_r;
  logic [STALL_W-1:0]  stall_n_r;
  logic [STALL_W-1:0]  stall_cnt_r;
  logic [DATA_W-1:0]   mem_r [MEM_WORDS];

  // Byte-offset bits below word granularity carry no meaning.
  logic unused_addr_s;
  assign unused_addr_s = ^avmm_slave_address[1:0];

  // Command acceptance; read+write together is accepted but treated as illegal.
  always_comb begin
    accept_s    = (avmm_slave_read | avmm_slave_write) & ~waitrequest_r;
    rd_push_s   = accept_s & avmm_slave_read;
    rd_acc_s    = accept_s & avmm_slave_read & ~avmm_slave_write;
    wr_acc_s    = accept_s & avmm_slave_write & ~avmm_slave_read;
    word_s      = avmm_slave_address[ADDR_W-1:2];
    mem_idx_s   = MEM_AW'(word_s - MEM_LO);
    stall_nxt_s = {1'b0, stall_cnt_r} + {{STALL_W{1'b0}}, 1'b1};
  end

  // Address decode to a single target.
  always_comb begin
    sel_s = SEL_NONE;
    if (word_s == W_ID) begin
      sel_s = SEL_ID;
    end else if (word_s == W_WR_CNT) begin
      sel_s = SEL_WR_CNT;
    end else if (word_s == W_RD_CNT) begin
      sel_s = SEL_RD_CNT;
    end else if (word_s == W_STATUS) begin
      sel_s = SEL_STATUS;
    end else if (word_s == W_STALL) begin
      sel_s = SEL_STALL;
    end else if ((word_s >= MEM_LO) && (word_s < MEM_HI)) begin
      sel_s = SEL_MEM;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Read data captured in the accept cycle; illegal or unmapped returns ERR_DATA.
  always_comb begin
    rd_data_s = ERR_DATA;
    if (avmm_slave_write) begin
      rd_data_s = ERR_DATA;
    end else begin
      case (sel_s)
        SEL_ID:     rd_data_s = ID_VALUE;
        SEL_WR_CNT: rd_data_s = wr_cnt_r;
        SEL_RD_CNT: rd_data_s = rd_cnt_r;
        SEL_STATUS: rd_data_s = {31'd0, err_r};
        SEL_STALL:  rd_data_s = {{(32-STALL_W){1'b0}}, stall_n_r};
        SEL_MEM:    rd_data_s = mem_r[mem_idx_s];
        default:    rd_data_s = ERR_DATA;
      endcase
    end
  end

  // Sticky error set/clear sources; a write to a read-only register is an error.
  always_comb begin
    err_set_s = 1'b0;
    err_clr_s = 1'b0;
    if (!accept_s) begin
      err_set_s = 1'b0;
    end else if (avmm_slave_read && avmm_slave_write) begin
      err_set_s = 1'b1;
    end else if (avmm_slave_read) begin
      err_set_s = (sel_s == SEL_NONE);
    end else begin
      err_set_s = sel_s inside {SEL_NONE, SEL_ID, SEL_WR_CNT, SEL_RD_CNT};
      err_clr_s = (sel_s == SEL_STATUS) & avmm_slave_writedata[0];
    end
  end

  // Counters, sticky error and stall configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_r  <= 32'd0;
      rd_cnt_r  <= 32'd0;
      err_r     <= 1'b0;
      stall_n_r <= {STALL_W{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_cnt_r <= wr_cnt_r + 32'd1;
      end
      if (rd_acc_s) begin
        rd_cnt_r <= rd_cnt_r + 32'd1;
      end
      err_r <= (err_r & ~err_clr_s) | err_set_s;
      if (wr_acc_s && (sel_s == SEL_STALL)) begin
        stall_n_r <= avmm_slave_writedata[STALL_W-1:0];
      end
    end
  end

  // Stall injector: after N accepted commands raise waitrequest for one cycle.
  // The comparison uses the N in force before the current command.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitrequest_r <= 1'b1;
      stall_cnt_r   <= {STALL_W{1'b0}};
    end else if (stall_n_r == {STALL_W{1'b0}}) begin
      waitrequest_r <= 1'b0;
      stall_cnt_r   <= {STALL_W{1'b0}};
    end else if (accept_s) begin
      if (stall_nxt_s >= {1'b0, stall_n_r}) begin
        waitrequest_r <= 1'b1;
        stall_cnt_r   <= {STALL_W{1'b0}};
      end else begin
        waitrequest_r <= 1'b0;
        stall_cnt_r   <= stall_nxt_s[STALL_W-1:0];
      end
    end else begin
      waitrequest_r <= 1'b0;
    end
  end

  // Scratch memory write with per-byte lane enables; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s && (sel_s == SEL_MEM)) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (avmm_slave_byteenable[b]) begin
          mem_r[mem_idx_s][8*b +: 8] <= avmm_slave_writedata[8*b +: 8];
        end
      end
    end
  end

  avmm_rd_delay_pipe #(
    .DEPTH  (READ_LATENCY),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .clr       (rst),
    .src_valid (rd_push_s),
    .src_data  (rd_data_s),
    .dly_valid (avmm_slave_readdatavalid),
    .dly_data  (avmm_slave_readdata)
  );

  assign avmm_slave_waitrequest = waitrequest_r;

endmodule
